// File: rtl/nios_cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the debug monitor RAM controller.
package nios_cpu_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    J_RD,
    J_CAP,
    C_RD,
    C_DONE
  } ocimem_state_e;

  localparam int JDO_RD_BIT  = 35;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  localparam int JDO_ADDR_LO = 17;

endpackage

// File: rtl/nios_cpu_ocimem_ram.sv
// Single-port 32-bit RAM, per-byte write enables, registered read (old data on write).
module nios_cpu_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/nios_cpu_debug_ocimem_ctrl.sv
// Debug monitor RAM controller: JTAG debug-slave commands plus CPU Avalon-MM slave port.
// Optional sticky address-wrap flag enabled by defining OCIMEM_WRAP_ERR_EN.
module nios_cpu_debug_ocimem_ctrl
  import nios_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              wrap_err,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       rdd_q, rdd_d;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              wait_c;

  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_data;
  logic              unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LO +: ADDR_W];
  assign jdo_data   = jdo[JDO_DATA_HI:JDO_DATA_LO];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mon_d     = mon_q;
    rdd_d     = rdd_q;
    ram_addr  = avs_address;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = jdo_data;
    wait_c    = 1'b1;

    if (state_q == J_CAP) mon_d = ram_rdata;
    if (state_q == C_RD && !(take_action_ocimem_a || take_action_ocimem_b ||
                             take_no_action_ocimem_a))
      rdd_d = ram_rdata;

    // JTAG strobes are never stalled; they preempt any CPU transaction in flight.
    if (take_action_ocimem_a) begin
      ram_addr = addr_q;
      addr_d   = jdo_addr;
      state_d  = jdo[JDO_RD_BIT] ? J_RD : IDLE;
    end else if (take_action_ocimem_b) begin
      ram_addr = addr_q;
      ram_we   = 1'b1;
      addr_d   = ADDR_W'(addr_q + 1'b1);
      state_d  = IDLE;
    end else if (take_no_action_ocimem_a) begin
      ram_addr = addr_q;
      addr_d   = ADDR_W'(addr_q + 1'b1);
      state_d  = J_RD;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (avs_write) begin
            ram_we    = 1'b1;
            ram_be    = avs_byteenable;
            ram_wdata = avs_writedata;
            wait_c    = 1'b0;
          end else if (avs_read) begin
            state_d = C_RD;
          end
        end
        J_RD: begin
          ram_addr = addr_q;
          state_d  = J_CAP;
        end
        J_CAP:  state_d = IDLE;
        C_RD:   state_d = C_DONE;
        C_DONE: begin
          wait_c  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      rdd_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      rdd_q   <= rdd_d;
    end
  end

  // Reset gates the write strobe so nothing lands in the RAM while reset is high.
  nios_cpu_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we & ~reset),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign MonDReg         = mon_q;
  assign avs_readdata    = rdd_q;
  assign jtag_busy       = (state_q == J_RD) || (state_q == J_CAP);
  assign avs_waitrequest = wait_c | reset;

`ifdef OCIMEM_WRAP_ERR_EN
  logic wrap_q;
  logic addr_inc;

  assign addr_inc = ~take_action_ocimem_a &
                    (take_action_ocimem_b | take_no_action_ocimem_a);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     wrap_q <= 1'b0;
    else if (addr_inc && &addr_q)  wrap_q <= 1'b1;
  end

  assign wrap_err = wrap_q;
`else
  assign wrap_err = 1'b0;
`endif

endmodule
